avalon_st_mul_slave: RTL and testbench
======================================

# avalon_st_mul_slave

Avalon-ST slave that sits directly downstream of the operand-sending master in the multiplier test path. It receives two 5-beat operand packets, A and B. Each packet is a header byte followed by 4 data bytes, MSB first. It multiplies the operands with a 32-cycle sequential multiplier and returns the 64-bit product as one 8-beat packet, MSB first, on its source interface.

## Interface
Parameters:
- DATA_W, 8, Avalon-ST symbol width; only 8 is supported.
- OPND_W, 32, operand width; the result is 2*OPND_W.

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- data_in  in  8  sink data.
- valid_in  in  1  sink valid.
- startofpacket_in  in  1  sink SOP; marks the header beat.
- endofpacket_in  in  1  sink EOP; marks the 4th data beat.
- ready_out  out  1  sink ready (registered).
- data_out  out  8  source data.
- valid_out  out  1  source valid.
- startofpacket_out  out  1  source SOP.
- endofpacket_out  out  1  source EOP.
- ready_in  in  1  source ready from the consumer.

## Operation
- A sink beat transfers when valid_in && ready_out. A source beat transfers when valid_out && ready_in.
- Top-level FSM has three states: COLLECT, MUL, TX.
- COLLECT:
  - ready_out=1.
  - The packet sub-FSM has three states: HDR, DATA (byte counter 0..3), SKIP.
  - HDR accepts only a beat with SOP=1; non-SOP beats are dropped.
  - Header values: 8'h01 selects A, 8'h02 selects B; any other value goes to SKIP.
  - DATA shifts bytes into a staging register, MSB first.
  - The 4th data byte must carry EOP=1. When it does, the staged value is copied to A or B and have_a or have_b is set.
  - Error cases:
    - EOP on data byte 0..2: the packet is discarded and the sub-FSM returns to HDR.
    - 4th data byte without EOP: the packet is discarded and the sub-FSM enters SKIP, staying there until an EOP beat.
    - SOP arriving in DATA or SKIP: that beat is treated as a new header (restart).
  - A repeated operand packet overwrites the previous value (last wins).
- COLLECT→MUL on the edge after both have_a and have_b are 1; ready_out drops to 0.
- MUL:
  - Sub-module seq_mul runs a shift-add over 32 iterations, one per cycle.
  - On done, the 64-bit product is loaded into the TX shift register.
- TX:
  - Emits 8 beats: product[63:56] first, [7:0] last.
  - SOP is set on beat 0 only; EOP is set on beat 7 only.
  - data_out, valid_out, SOP and EOP hold stable while ready_in=0.
  - After the EOP beat transfers: valid_out=0, have_a=have_b=0, and the FSM returns to COLLECT with ready_out=1.
- Sink beats are not accepted during MUL or TX (ready_out=0).
- Reset values:
  - data_out=0, valid_out=0, startofpacket_out=0, endofpacket_out=0, ready_out=1.
  - A=B=0, have flags 0, FSM in COLLECT/HDR, multiplier idle.
- Reset asserted mid-packet, mid-MUL or mid-TX aborts everything immediately; a partial result is never emitted.

## Timing
- Operand capture: A or B is updated on the same edge that accepts its EOP beat.
- Let N be the edge that accepts the last EOP beat completing {A,B}.
  - ready_out is 0 after edge N.
  - The multiplier starts at N+1 and iterates on edges N+1..N+32.
  - At N+33, valid_out=1, startofpacket_out=1 and data_out=product[63:56].
- With ready_in held at 1, the 8 result beats occupy 8 consecutive cycles. ready_out returns to 1 the cycle after the EOP beat transfers.
- With ready_in held at 1, the minimum turnaround is 10 sink beats plus 41 cycles.
- ready_in has no combinational path to ready_out.

## Configuration
- Macro AVST_MUL_SIGNED_EN.
- Defined: A and B are two's-complement.
  - seq_mul multiplies magnitudes.
  - The result is negated when sign(A)^sign(B).
  - Latency is unchanged (the sign fix is folded into the done cycle).
- Undefined: unsigned 32x32 multiply; the sign logic is not compiled.

## Structure
- Package avst_mul_pkg holds:
  - HDR_A=8'h01 and HDR_B=8'h02.
  - OPND_BYTES=4 and RES_BYTES=8.
  - Enum typedefs for the top FSM (COLLECT/MUL/TX) and the packet FSM (HDR/DATA/SKIP).
- Sub-module seq_mul:
  - Interface: start, a, b, done, product; done is a 1-cycle pulse.
  - It is instantiated once.

## Test plan
- Basic: send A=32'h0000_0003 then B=32'h0000_0005, ready_in=1 → 8 beats 00 00 00 00 00 00 00 0F, SOP on beat 0, EOP on beat 7, first valid_out exactly 33 cycles after B's EOP edge.
- Max values: A=B=32'hFFFF_FFFF with the macro undefined → FFFF_FFFE_0000_0001. With AVST_MUL_SIGNED_EN defined → 0000_0000_0000_0001.
- Backpressure: toggle ready_in 1,0,0,1,... during TX → each byte held while ready_in=0, no byte dropped or duplicated, 8 beats total.
- Malformed packets:
  - Header 8'h07 → no operand change.
  - Header 8'h01 with EOP on data byte 1 → A unchanged.
  - Follow with valid A and B packets → correct product.
- Order and overwrite: send B=2, A=7, then check the result; then send A=9 twice and B=4 → results 14, then 36.
- Reset during TX beat 3 → all outputs reset next cycle, ready_out=1. A new A/B pair afterwards yields the correct full 8-beat packet.

Source files
------------

// File: rtl/avst_mul_pkg.sv
// Shared constants and state types for the Avalon-ST multiplier slave.
// Build option: AVST_MUL_SIGNED_EN (two's-complement operands) is consumed by
// avalon_st_mul_slave; this package is the same in both builds.
package avst_mul_pkg;

  localparam logic [7:0] HDR_A = 8'h01;
  localparam logic [7:0] HDR_B = 8'h02;

  localparam int unsigned OPND_BYTES = 4;
  localparam int unsigned RES_BYTES  = 8;

  typedef enum logic [1:0] {
    COLLECT,
    MUL,
    TX
  } top_state_e;

  typedef enum logic [1:0] {
    HDR,
    DATA,
    SKIP
  } pkt_state_e;

endpackage

// File: rtl/seq_mul.sv
// Unsigned W x W shift-add multiplier, one partial product per cycle.
// Ports: clk, rst (async, active-high); start_i loads a_i/b_i and performs the
// first iteration on the same edge; done_o pulses for one cycle once all W
// iterations have completed, with product_o valid from then until next start.
module seq_mul #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_o,
  output logic [2*W-1:0] product_o
);

  localparam int unsigned CNT_W = $clog2(W);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [2*W-1:0]   p_q, p_d;

  // One iteration: add multiplicand into the upper half when the multiplier
  // LSB is set, then shift the whole register right (carry enters the MSB).
  function automatic logic [2*W-1:0] step(input logic [2*W-1:0] p,
                                          input logic [W-1:0]   m);
    logic [W:0] sum;
    sum = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : (W+1)'(0));
    return {sum, p[W-1:1]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      p_q     <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    if (start_i) begin
      mcand_d = a_i;
      p_d     = step({W'(0), b_i}, a_i);
      cnt_d   = CNT_W'(1);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      p_d   = step(p_q, mcand_q);
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign done_o    = done_q;
  assign product_o = p_q;

endmodule

// File: rtl/avalon_st_mul_slave.sv
// Avalon-ST slave: collects operand packets A (hdr 8'h01) and B (hdr 8'h02),
// each a header beat plus 4 data bytes MSB first, multiplies them with seq_mul
// and returns the 2*OPND_W-bit product as one 8-beat packet, MSB first.
// Ports: clk, rst (async, active-high); sink data_in/valid_in/
// startofpacket_in/endofpacket_in with registered ready_out; source data_out/
// valid_out/startofpacket_out/endofpacket_out with ready_in backpressure.
// Build option: AVST_MUL_SIGNED_EN treats operands as two's-complement.
module avalon_st_mul_slave
  import avst_mul_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OPND_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              startofpacket_in,
  input  logic              endofpacket_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              startofpacket_out,
  output logic              endofpacket_out,
  input  logic              ready_in
);

  localparam int unsigned RES_W = 2 * OPND_W;

  top_state_e        state_q, state_d;
  pkt_state_e        pkt_q, pkt_d;
  logic              sel_b_q, sel_b_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [OPND_W-1:0] stage_q, stage_d;
  logic [OPND_W-1:0] a_q, a_d, b_q, b_d;
  logic              have_a_q, have_a_d, have_b_q, have_b_d;
  logic              start_q, start_d;
  logic              ready_q, ready_d;
  logic [RES_W-1:0]  tx_sr_q, tx_sr_d;
  logic [2:0]        beat_q, beat_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;

  logic              sink_fire_c;
  logic [OPND_W-1:0] mul_a_c, mul_b_c;
  logic              mul_done_c;
  logic [RES_W-1:0]  mul_p_c, prod_c;

`ifdef AVST_MUL_SIGNED_EN
  // Multiply magnitudes; operands are stable through MUL so the sign is
  // taken straight from A/B when the product is loaded.
  logic neg_c;
  assign neg_c   = a_q[OPND_W-1] ^ b_q[OPND_W-1];
  assign mul_a_c = a_q[OPND_W-1] ? -a_q : a_q;
  assign mul_b_c = b_q[OPND_W-1] ? -b_q : b_q;
  assign prod_c  = neg_c ? -mul_p_c : mul_p_c;
`else
  assign mul_a_c = a_q;
  assign mul_b_c = b_q;
  assign prod_c  = mul_p_c;
`endif

  seq_mul #(.W(OPND_W)) u_seq_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_q),
    .a_i       (mul_a_c),
    .b_i       (mul_b_c),
    .done_o    (mul_done_c),
    .product_o (mul_p_c)
  );

  assign sink_fire_c = valid_in && ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= COLLECT;
      pkt_q    <= HDR;
      sel_b_q  <= 1'b0;
      cnt_q    <= '0;
      stage_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      have_a_q <= 1'b0;
      have_b_q <= 1'b0;
      start_q  <= 1'b0;
      ready_q  <= 1'b1;
      tx_sr_q  <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pkt_q    <= pkt_d;
      sel_b_q  <= sel_b_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      a_q      <= a_d;
      b_q      <= b_d;
      have_a_q <= have_a_d;
      have_b_q <= have_b_d;
      start_q  <= start_d;
      ready_q  <= ready_d;
      tx_sr_q  <= tx_sr_d;
      beat_q   <= beat_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pkt_d    = pkt_q;
    sel_b_d  = sel_b_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    a_d      = a_q;
    b_d      = b_q;
    have_a_d = have_a_q;
    have_b_d = have_b_q;
    start_d  = 1'b0;
    ready_d  = ready_q;
    tx_sr_d  = tx_sr_q;
    beat_d   = beat_q;
    valid_d  = valid_q;
    sop_d    = sop_q;
    eop_d    = eop_q;

    case (state_q)
      COLLECT: begin
        if (sink_fire_c) begin
          if (startofpacket_in) begin
            // Any SOP beat restarts parsing as a header.
            cnt_d = '0;
            if (endofpacket_in) begin
              pkt_d = HDR;
            end else if (data_in == HDR_A) begin
              pkt_d   = DATA;
              sel_b_d = 1'b0;
            end else if (data_in == HDR_B) begin
              pkt_d   = DATA;
              sel_b_d = 1'b1;
            end else begin
              pkt_d = SKIP;
            end
          end else begin
            case (pkt_q)
              DATA: begin
                stage_d = {stage_q[OPND_W-DATA_W-1:0], data_in};
                if (cnt_q == 2'(OPND_BYTES - 1)) begin
                  if (endofpacket_in) begin
                    pkt_d = HDR;
                    if (sel_b_q) begin
                      b_d      = stage_d;
                      have_b_d = 1'b1;
                    end else begin
                      a_d      = stage_d;
                      have_a_d = 1'b1;
                    end
                  end else begin
                    pkt_d = SKIP;
                  end
                end else if (endofpacket_in) begin
                  pkt_d = HDR;
                end else begin
                  cnt_d = cnt_q + 2'd1;
                end
              end
              SKIP: begin
                if (endofpacket_in) pkt_d = HDR;
              end
              default: ;
            endcase
          end
        end
        if (have_a_d && have_b_d) begin
          state_d = MUL;
          start_d = 1'b1;
          ready_d = 1'b0;
        end
      end

      MUL: begin
        if (mul_done_c) begin
          state_d = TX;
          tx_sr_d = prod_c;
          beat_d  = '0;
          valid_d = 1'b1;
          sop_d   = 1'b1;
          eop_d   = 1'b0;
        end
      end

      TX: begin
        if (valid_q && ready_in) begin
          tx_sr_d = {tx_sr_q[RES_W-DATA_W-1:0], DATA_W'(0)};
          beat_d  = beat_q + 3'd1;
          sop_d   = 1'b0;
          if (beat_q == 3'(RES_BYTES - 1)) begin
            valid_d  = 1'b0;
            eop_d    = 1'b0;
            have_a_d = 1'b0;
            have_b_d = 1'b0;
            state_d  = COLLECT;
            ready_d  = 1'b1;
          end else begin
            eop_d = (beat_q == 3'(RES_BYTES - 2));
          end
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  assign ready_out         = ready_q;
  assign data_out          = tx_sr_q[RES_W-1 -: DATA_W];
  assign valid_out         = valid_q;
  assign startofpacket_out = sop_q;
  assign endofpacket_out   = eop_q;

endmodule

// File: tb/tb_avalon_st_mul_slave.sv
// Directed bench for avalon_st_mul_slave with an operand/product model and a
// per-cycle source-side checker.
module tb_avalon_st_mul_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in, startofpacket_in, endofpacket_in;
  logic       ready_out;
  logic [7:0] data_out;
  logic       valid_out, startofpacket_out, endofpacket_out;
  logic       ready_in;

  avalon_st_mul_slave dut (
    .clk               (clk),
    .rst               (rst),
    .data_in           (data_in),
    .valid_in          (valid_in),
    .startofpacket_in  (startofpacket_in),
    .endofpacket_in    (endofpacket_in),
    .ready_out         (ready_out),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .startofpacket_out (startofpacket_out),
    .endofpacket_out   (endofpacket_out),
    .ready_in          (ready_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
  } beat_t;

  beat_t       exp_q[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] m_a = '0, m_b = '0;
  bit          m_ha = 0, m_hb = 0;
  logic [63:0] rx_word = '0;
  int          rx_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b);
`ifdef AVST_MUL_SIGNED_EN
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
`else
    return {32'h0, a} * {32'h0, b};
`endif
  endfunction

  task automatic push_result();
    logic [63:0] p;
    beat_t       bt;
    p = model_prod(m_a, m_b);
    for (int i = 0; i < 8; i++) begin
      bt.d = p[63-8*i -: 8];
      bt.s = (i == 0);
      bt.e = (i == 7);
      exp_q.push_back(bt);
    end
    m_ha = 0;
    m_hb = 0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
    int t;
    @(negedge clk);
    data_in = d; valid_in = 1'b1; startofpacket_in = s; endofpacket_in = e;
    t = 0;
    while (!ready_out && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!ready_out) chk("sink_ready_timeout", 64'(ready_out), 64'd1);
    @(posedge clk);
    #1;
    valid_in = 1'b0; startofpacket_in = 1'b0; endofpacket_in = 1'b0;
  endtask

  // n_data data bytes follow the header; the last carries EOP if eop_last.
  task automatic send_pkt(input logic [7:0] hdr, input logic [31:0] val,
                          input int n_data, input bit eop_last);
    logic [7:0] b;
    send_beat(hdr, 1'b1, 1'b0);
    for (int i = 0; i < n_data; i++) begin
      b = (i < 4) ? val[31-8*i -: 8] : 8'hAA;
      send_beat(b, 1'b0, eop_last && (i == n_data - 1));
    end
    if (n_data == 4 && eop_last) begin
      if (hdr == 8'h01) begin m_a = val; m_ha = 1; end
      if (hdr == 8'h02) begin m_b = val; m_hb = 1; end
      if (m_ha && m_hb) push_result();
    end
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !ready_out) && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({nm, "_beats_left"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_ready_back"}, 64'(ready_out), 64'd1);
  endtask

  // Source-side checker: every transferred beat against the model queue,
  // and output stability while the consumer stalls.
  logic       hold = 1'b0;
  logic [9:0] held;
  always @(negedge clk) begin
    beat_t bt;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 64'(valid_out), 64'd1);
        chk("hold_stable", 64'({data_out, startofpacket_out, endofpacket_out}), 64'(held));
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(data_out), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          bt = exp_q.pop_front();
          chk("beat", 64'({data_out, startofpacket_out, endofpacket_out}),
              64'({bt.d, bt.s, bt.e}));
        end
        rx_word = startofpacket_out ? {56'h0, data_out} : {rx_word[55:0], data_out};
        rx_cnt++;
        hold = 1'b0;
      end else if (valid_out) begin
        hold = 1'b1;
        held = {data_out, startofpacket_out, endofpacket_out};
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    int base, t;
    rst = 1'b1;
    data_in = '0; valid_in = 0; startofpacket_in = 0; endofpacket_in = 0;
    ready_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_sop", 64'(startofpacket_out), 64'd0);
    chk("rst_eop", 64'(endofpacket_out), 64'd0);
    rst = 1'b0;

    // Basic product with latency pinned from B's EOP edge.
    send_pkt(8'h01, 32'h0000_0003, 4, 1);
    send_pkt(8'h02, 32'h0000_0005, 4, 1);
    chk("ready_low_after_N", 64'(ready_out), 64'd0);
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
    end
    chk("valid_low_N32", 64'(valid_out), 64'd0);
    @(posedge clk);
    #1;
    chk("valid_N33", 64'({valid_out, startofpacket_out, data_out}), 64'({1'b1, 1'b1, 8'h00}));
    wait_idle("basic");
    chk("basic_word", rx_word, 64'h0000_0000_0000_000F);

    // Max operands.
    send_pkt(8'h01, 32'hFFFF_FFFF, 4, 1);
    send_pkt(8'h02, 32'hFFFF_FFFF, 4, 1);
    wait_idle("max");
`ifdef AVST_MUL_SIGNED_EN
    chk("max_word", rx_word, 64'h0000_0000_0000_0001);
`else
    chk("max_word", rx_word, 64'hFFFF_FFFE_0000_0001);
`endif

    // Backpressure 1,0,0,1 during TX.
    base = rx_cnt;
    send_pkt(8'h01, 32'h0123_4567, 4, 1);
    send_pkt(8'h02, 32'h0000_0100, 4, 1);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
      ready_in = ((k % 4) == 0) || ((k % 4) == 3);
    end
    ready_in = 1'b1;
    wait_idle("bp");
    chk("bp_count", 64'(rx_cnt - base), 64'd8);
    chk("bp_word", rx_word, 64'h0000_0001_2345_6700);

    // Malformed packets must not touch A or complete the pair.
    send_pkt(8'h02, 32'h0000_0003, 4, 1);
    send_pkt(8'h07, 32'h1111_1111, 4, 1);
    send_pkt(8'h01, 32'h2222_2222, 2, 1);
    send_beat(8'h55, 1'b0, 1'b0);
    send_pkt(8'h01, 32'h3333_3333, 5, 1);
    repeat (40) @(posedge clk);
    #1;
    chk("malformed_no_result", 64'({valid_out, ready_out}), 64'({1'b0, 1'b1}));
    send_pkt(8'h01, 32'h0000_1234, 4, 1);
    wait_idle("malformed");
    chk("malformed_word", rx_word, 64'h0000_0000_0000_369C);

    // Order and overwrite.
    send_pkt(8'h02, 32'd2, 4, 1);
    send_pkt(8'h01, 32'd7, 4, 1);
    wait_idle("order");
    chk("order_word", rx_word, 64'd14);
    send_pkt(8'h01, 32'd9, 4, 1);
    send_pkt(8'h01, 32'd9, 4, 1);
    send_pkt(8'h02, 32'd4, 4, 1);
    wait_idle("overwrite");
    chk("overwrite_word", rx_word, 64'd36);

    // Reset while beat 3 is on the source.
    base = rx_cnt;
    send_pkt(8'h01, 32'h0000_1111, 4, 1);
    send_pkt(8'h02, 32'h0000_2222, 4, 1);
    t = 0;
    while (rx_cnt != base + 3 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("tx_beat3_reached", 64'(rx_cnt - base), 64'd3);
    rst = 1'b1;
    exp_q.delete();
    m_a = '0; m_b = '0; m_ha = 0; m_hb = 0;
    @(posedge clk);
    #1;
    chk("midtx_rst_outs", 64'({valid_out, startofpacket_out, endofpacket_out, data_out}), 64'd0);
    chk("midtx_rst_ready", 64'(ready_out), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    chk("no_partial_after_rst", 64'(valid_out), 64'd0);
    base = rx_cnt;
    send_pkt(8'h01, 32'h0000_0100, 4, 1);
    send_pkt(8'h02, 32'h0000_0100, 4, 1);
    wait_idle("post_rst");
    chk("post_rst_count", 64'(rx_cnt - base), 64'd8);
    chk("post_rst_word", rx_word, 64'h0000_0000_0001_0000);

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
